controle_multiciclo: RTL and testbench

- Parametrised multi-cycle control unit for the accumulator CPU; supersedes the purely combinational opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Handshakes with instruction/data memory via mem_req/mem_ready, with a configurable timeout.
- Drives datapath strobes (A/B load, ALU op, PC, IR), adds HLT/NOP opcodes and a bus-error halt.

---
 rtl/controle_multiciclo.sv | 276 +++++++++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multi-cycle control unit for the accumulator CPU. It steps each instruction
// through START/FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes.
// A memory timeout or a HLT opcode stops the FSM in HALT, and only rst
// releases it.
//
// Optional feature: define CONTROLE_ILLEGAL_TRAP_EN to make illegal opcodes
// halt with illegal_op=1. Without it, an illegal opcode retires as a NOP and
// illegal_op is tied to 0.
//
// Parameters:
//   OPCODE_W    opcode width (>=4). Any nonzero bit above [3:0] is illegal.
//   ALUOP_W     alu_op width (>=3). Codes are zero-extended.
//   MEM_TIMEOUT max wait cycles for mem_ready in FETCH/MEM. 0 = no timeout.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   opcode                   from IR, stable from DECODE until back in FETCH
//   zero_flag, eq_flag       branch conditions for JMP / BEQ
//   mem_ready                memory completes the current request this cycle
//   mem_req, mem_we          memory request / write request
//   mem_addr_sel, store_sel  address mux (0=PC, 1=operand), store data (0=A, 1=B)
//   ir_write, pc_write       latch instruction / update PC
//   pc_src                   0=PC+1, 1=branch target
//   load_a, load_b           accumulator / B register load
//   use_imm                  ALU B input takes the immediate
//   alu_op                   ADD=0, SUB=1, AND=2, OR=3, PASS_IMM=4
//   write_back_mem           write the ALU result
//   instr_done               one-cycle retire pulse
//   halted, bus_err          in HALT / halt caused by memory timeout
//   illegal_op               halt caused by illegal opcode (feature only)
//   state_dbg                START=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//
// Memory handshake: mem_req is a Moore output. It is high for every cycle the
// FSM sits in FETCH or MEM. The request completes in the first cycle where
// mem_req and mem_ready are both high. mem_ready is ignored in all other states.
// -----------------------------------------------------------------------------
module controle_multiciclo #(
  parameter int OPCODE_W    = 4,
  parameter int ALUOP_W     = 3,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                zero_flag,
  input  logic                eq_flag,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                mem_addr_sel,
  output logic                store_sel,
  output logic                ir_write,
  output logic                pc_write,
  output logic                pc_src,
  output logic                load_a,
  output logic                load_b,
  output logic                use_imm,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                write_back_mem,
  output logic                instr_done,
  output logic                halted,
  output logic                bus_err,
  output logic                illegal_op,
  output logic [2:0]          state_dbg
);

  typedef enum logic [2:0] {
    S_START  = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    I_ADD, I_SUB, I_AND, I_OR,
    I_LDA, I_STA, I_LDB, I_STB,
    I_LDC, I_JMP, I_BEQ,
    I_NOP, I_HLT, I_ILL
  } instr_t;

  // The counter only has to reach MEM_TIMEOUT-1. The wait that would make it
  // reach MEM_TIMEOUT goes straight to HALT instead.
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LIMIT = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t           state;
  instr_t           instr;
  logic [CNT_W-1:0] waitCnt;
  logic [2:0]       aluCode;
  logic             busErr;
  logic             timeoutHit;

  // Opcode classification. Upper bits above [3:0] must be zero.
  always_comb begin
    instr = I_ILL;
    if ((opcode >> 4) == '0) begin
      case (opcode[3:0])
        4'b0000: instr = I_ADD;
        4'b0001: instr = I_SUB;
        4'b0010: instr = I_LDA;
        4'b0011: instr = I_STA;
        4'b0100: instr = I_LDB;
        4'b0101: instr = I_STB;
        4'b0110: instr = I_LDC;
        4'b0111: instr = I_JMP;
        4'b1000: instr = I_AND;
        4'b1001: instr = I_OR;
        4'b1010: instr = I_BEQ;
        4'b1011: instr = I_NOP;
        4'b1111: instr = I_HLT;
        default: instr = I_ILL;
      endcase
    end
  end

  always_comb begin
    aluCode = 3'd0;
    case (instr)
      I_SUB:   aluCode = 3'd1;
      I_AND:   aluCode = 3'd2;
      I_OR:    aluCode = 3'd3;
      I_LDC:   aluCode = 3'd4;
      default: aluCode = 3'd0;
    endcase
  end

  // This is the last allowed wait. Seeing no mem_ready now means timeout.
  assign timeoutHit = (MEM_TIMEOUT != 0) && (waitCnt == CNT_W'(LIMIT));

`ifdef CONTROLE_ILLEGAL_TRAP_EN
  logic illegalOp;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_START;
      waitCnt <= '0;
      busErr  <= 1'b0;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
      illegalOp <= 1'b0;
`endif
    end else begin
      // The counter only keeps counting while a memory request waits.
      // Any other path clears it, so it is zero on every entry to FETCH/MEM.
      waitCnt <= '0;
      case (state)
        S_START: state <= S_FETCH;
        S_FETCH, S_MEM: begin
          if (mem_ready) begin
            state <= (state == S_FETCH) ? S_DECODE : S_FETCH;
          end else if (timeoutHit) begin
            state  <= S_HALT;
            busErr <= 1'b1;
          end else begin
            waitCnt <= waitCnt + CNT_W'(1);
          end
        end
        S_DECODE: begin
          case (instr)
            I_ADD, I_SUB, I_AND, I_OR,
            I_LDC, I_JMP, I_BEQ:          state <= S_EXEC;
            I_LDA, I_STA, I_LDB, I_STB:   state <= S_MEM;
            I_HLT:                        state <= S_HALT;
            I_ILL: begin
`ifdef CONTROLE_ILLEGAL_TRAP_EN
              state     <= S_HALT;
              illegalOp <= 1'b1;
`else
              state     <= S_FETCH;
`endif
            end
            default:                      state <= S_FETCH;
          endcase
        end
        S_EXEC: begin
          if (instr == I_ADD || instr == I_SUB || instr == I_AND || instr == I_OR)
            state <= S_WB;
          else
            state <= S_FETCH;
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_START;
      endcase
    end
  end

  // Moore strobes depend on state only. alu_op also follows the opcode,
  // which is stable from DECODE onward. Mealy strobes also need mem_ready
  // or a branch flag.
  always_comb begin
    mem_req        = 1'b0;
    mem_we         = 1'b0;
    mem_addr_sel   = 1'b0;
    store_sel      = 1'b0;
    ir_write       = 1'b0;
    pc_write       = 1'b0;
    pc_src         = 1'b0;
    load_a         = 1'b0;
    load_b         = 1'b0;
    use_imm        = 1'b0;
    alu_op         = '0;
    write_back_mem = 1'b0;
    instr_done     = 1'b0;
    halted         = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      S_DECODE: begin
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        instr_done = (instr == I_NOP);
`else
        instr_done = (instr == I_NOP) || (instr == I_ILL);
`endif
      end
      S_EXEC: begin
        alu_op = ALUOP_W'(aluCode);
        case (instr)
          I_LDC: begin
            use_imm    = 1'b1;
            load_a     = 1'b1;
            instr_done = 1'b1;
          end
          I_JMP: begin
            pc_write   = zero_flag;
            pc_src     = zero_flag;
            instr_done = 1'b1;
          end
          I_BEQ: begin
            pc_write   = eq_flag;
            pc_src     = eq_flag;
            instr_done = 1'b1;
          end
          default: ;
        endcase
      end
      S_WB: begin
        alu_op         = ALUOP_W'(aluCode);
        write_back_mem = 1'b1;
        instr_done     = 1'b1;
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (instr == I_STA) || (instr == I_STB);
        store_sel    = (instr == I_STB);
        if (mem_ready) begin
          load_a     = (instr == I_LDA);
          load_b     = (instr == I_LDB);
          instr_done = 1'b1;
        end
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign bus_err   = busErr;
  assign state_dbg = state;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
  assign illegal_op = illegalOp;
`else
  assign illegal_op = 1'b0;
`endif

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Bench for controle_multiciclo. It uses a 5-bit opcode so that an upper
// opcode bit can be set, and MEM_TIMEOUT=4. A trace model builds the
// expected per-cycle outputs of every instruction from the instruction
// classes. Directed scenarios cover reset, timeout, HLT and illegal opcodes.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;
  localparam int OW  = 5;
  localparam int AW  = 3;
  localparam int TMO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [OW-1:0] opcode = '0;
  logic          zero_flag = 1'b0;
  logic          eq_flag = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, mem_addr_sel, store_sel, ir_write, pc_write;
  logic          pc_src, load_a, load_b, use_imm, write_back_mem, instr_done;
  logic          halted, bus_err, illegal_op;
  logic [AW-1:0] alu_op;
  logic [2:0]    state_dbg;

  typedef struct packed {
    logic [2:0]    st;
    logic          req, we, asel, ssel, irw, pcw, pcs, la, lb, imm;
    logic [AW-1:0] aop;
    logic          wb, done, hlt, be, ill;
  } out_t;
  localparam int EW = $bits(out_t);

  out_t obs, e;
  assign obs = {state_dbg, mem_req, mem_we, mem_addr_sel, store_sel, ir_write,
                pc_write, pc_src, load_a, load_b, use_imm, alu_op,
                write_back_mem, instr_done, halted, bus_err, illegal_op};

  logic [EW-1:0]   exp_q[$];
  logic [OW+2:0]   stim_q[$];   // {opcode, zero_flag, eq_flag, mem_ready}
  int total = 0;
  int bad   = 0;

  controle_multiciclo #(.OPCODE_W(OW), .ALUOP_W(AW), .MEM_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero_flag(zero_flag),
    .eq_flag(eq_flag), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .store_sel(store_sel),
    .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .load_a(load_a), .load_b(load_b), .use_imm(use_imm), .alu_op(alu_op),
    .write_back_mem(write_back_mem), .instr_done(instr_done),
    .halted(halted), .bus_err(bus_err), .illegal_op(illegal_op),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Holds reset for two cycles and releases it on a negedge. The DUT is in
  // START for the rest of that cycle and enters FETCH at the next posedge.
  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- reference trace model ----------------
  function automatic void push_cycle(input out_t x, input logic [OW-1:0] op,
                                     input logic zf, input logic ef, input logic rdy);
    exp_q.push_back(x);
    stim_q.push_back({op, zf, ef, rdy});
  endfunction

  function automatic logic is_illegal(input logic [OW-1:0] op);
    logic [3:0] lo;
    lo = op[3:0];
    return (op[OW-1:4] != '0) || (lo == 4'd12) || (lo == 4'd13) || (lo == 4'd14);
  endfunction

  // Appends the whole expected trace of one instruction, starting in FETCH.
  // fd and md are the cycles without mem_ready before memory answers in
  // FETCH and MEM. mem_ready is randomized in the cycles where it must be
  // ignored.
  task automatic plan_instr(input logic [OW-1:0] op, input int fd, input int md,
                            input logic zf, input logic ef);
    out_t x;
    logic [3:0] lo;
    logic ill, c;
    lo  = op[3:0];
    ill = is_illegal(op);
    x = '0; x.st = 3'd1; x.req = 1'b1;
    for (int i = 0; i < fd; i++) push_cycle(x, op, zf, ef, 1'b0);
    x.irw = 1'b1; x.pcw = 1'b1;
    push_cycle(x, op, zf, ef, 1'b1);
    x = '0; x.st = 3'd2;
    x.done = (lo == 4'd11 && !ill) || ill;
    push_cycle(x, op, zf, ef, 1'($urandom_range(0, 1)));
    if (ill || lo == 4'd11) return;
    x = '0;
    case (lo)
      4'd0, 4'd1, 4'd8, 4'd9: begin
        x.st  = 3'd3;
        x.aop = (lo == 4'd0) ? 3'd0 : (lo == 4'd1) ? 3'd1 : (lo == 4'd8) ? 3'd2 : 3'd3;
        push_cycle(x, op, zf, ef, 1'($urandom_range(0, 1)));
        x.st = 3'd5; x.wb = 1'b1; x.done = 1'b1;
        push_cycle(x, op, zf, ef, 1'($urandom_range(0, 1)));
      end
      4'd6: begin
        x.st = 3'd3; x.imm = 1'b1; x.aop = 3'd4; x.la = 1'b1; x.done = 1'b1;
        push_cycle(x, op, zf, ef, 1'($urandom_range(0, 1)));
      end
      4'd7, 4'd10: begin
        c = (lo == 4'd7) ? zf : ef;
        x.st = 3'd3; x.pcw = c; x.pcs = c; x.done = 1'b1;
        push_cycle(x, op, zf, ef, 1'($urandom_range(0, 1)));
      end
      default: begin  // LDA=2, STA=3, LDB=4, STB=5
        x.st = 3'd4; x.req = 1'b1; x.asel = 1'b1;
        x.we = (lo == 4'd3) || (lo == 4'd5);
        x.ssel = (lo == 4'd5);
        for (int i = 0; i < md; i++) push_cycle(x, op, zf, ef, 1'b0);
        x.la = (lo == 4'd2); x.lb = (lo == 4'd4); x.done = 1'b1;
        push_cycle(x, op, zf, ef, 1'b1);
      end
    endcase
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); #1;
    e = '0; total++;
    if (obs !== e) begin bad++; $display("FAIL reset_hold got=%h exp=%h", obs, e); end
    rst = 1'b0; #1;
    e = '0; total++;
    if (obs !== e) begin bad++; $display("FAIL reset_start got=%h exp=%h", obs, e); end
    @(negedge clk); #1;
    e = '0; e.st = 3'd1; e.req = 1'b1; total++;
    if (obs !== e) begin bad++; $display("FAIL reset_fetch got=%h exp=%h", obs, e); end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    opcode = 5'd4;
    @(negedge clk); mem_ready = 1'b1;   // FETCH
    @(negedge clk); mem_ready = 1'b0;   // DECODE
    @(negedge clk); mem_ready = 1'b1; #1;
    e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1; e.lb = 1'b1; e.done = 1'b1;
    total++;
    if (obs !== e) begin bad++; $display("FAIL mid_mem_ready got=%h exp=%h", obs, e); end
    #1 rst = 1'b1; #1;
    e = '0; total++;
    if (obs !== e) begin bad++; $display("FAIL mid_mem_reset got=%h exp=%h", obs, e); end
    mem_ready = 1'b0;
    @(negedge clk); rst = 1'b0; #1;
    e = '0; total++;
    if (obs !== e) begin bad++; $display("FAIL mid_mem_start got=%h exp=%h", obs, e); end
    @(negedge clk); #1;
    e = '0; e.st = 3'd1; e.req = 1'b1; total++;
    if (obs !== e) begin bad++; $display("FAIL mid_mem_fetch got=%h exp=%h", obs, e); end
  endtask

  // Directed instruction traces: ADD, LDB with a 2-cycle wait, BEQ both ways,
  // NOP, and fetch/mem waits at the timeout boundary.
  task automatic test_directed();
    do_reset();
    plan_instr(5'd0,  0, 0, 1'b0, 1'b0);
    plan_instr(5'd4,  0, 2, 1'b0, 1'b0);
    plan_instr(5'd10, 0, 0, 1'b0, 1'b1);
    plan_instr(5'd10, 0, 0, 1'b1, 1'b0);
    plan_instr(5'd7,  1, 0, 1'b1, 1'b0);
    plan_instr(5'd11, 0, 0, 1'b0, 1'b0);
    plan_instr(5'd5,  TMO - 1, TMO - 1, 1'b0, 1'b0);
    plan_instr(5'd6,  2, 0, 1'b0, 1'b0);
    while (exp_q.size() > 0) begin
      @(negedge clk);
      {opcode, zero_flag, eq_flag, mem_ready} = stim_q.pop_front();
      #1;
      e = out_t'(exp_q.pop_front());
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL directed op=%0d got=%h exp=%h", opcode, obs, e);
      end
    end
  endtask

  task automatic test_random();
    logic [OW-1:0] op;
    int v;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      v = $urandom_range(0, 19);
      if (v >= 16) op = {1'b1, 4'($urandom_range(0, 15))};
      else         op = OW'(v);
      if (op == 5'd15) op = 5'd11;
`ifdef CONTROLE_ILLEGAL_TRAP_EN
      if (is_illegal(op)) op = 5'd11;
`endif
      plan_instr(op, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    while (exp_q.size() > 0) begin
      @(negedge clk);
      {opcode, zero_flag, eq_flag, mem_ready} = stim_q.pop_front();
      #1;
      e = out_t'(exp_q.pop_front());
      total++;
      if (obs !== e) begin
        bad++;
        $display("FAIL random op=%0d got=%h exp=%h", opcode, obs, e);
      end
    end
  endtask

  task automatic test_timeout();
    // FETCH never answered: TMO request cycles, then sticky HALT with bus_err.
    do_reset();
    opcode = 5'd0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk); #1;
      e = '0; e.st = 3'd1; e.req = 1'b1; total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_fetch_wait got=%h exp=%h", obs, e); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
      e = '0; e.st = 3'd6; e.hlt = 1'b1; e.be = 1'b1; total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_halt got=%h exp=%h", obs, e); end
    end
    // MEM never answered: the same halt path from the data side.
    do_reset();
    opcode = 5'd2;
    @(negedge clk); mem_ready = 1'b1;
    @(negedge clk); mem_ready = 1'b0;
    for (int c = 0; c < TMO; c++) begin
      @(negedge clk); #1;
      e = '0; e.st = 3'd4; e.req = 1'b1; e.asel = 1'b1; total++;
      if (obs !== e) begin bad++; $display("FAIL tmo_mem_wait got=%h exp=%h", obs, e); end
    end
    @(negedge clk); #1;
    e = '0; e.st = 3'd6; e.hlt = 1'b1; e.be = 1'b1; total++;
    if (obs !== e) begin bad++; $display("FAIL tmo_mem_halt got=%h exp=%h", obs, e); end
  endtask

  task automatic test_halt_ops();
    logic [OW-1:0] ops[3];
    ops[0] = 5'd15; ops[1] = 5'd12; ops[2] = 5'd16;
    for (int k = 0; k < 3; k++) begin
      do_reset();
      opcode = ops[k];
      @(negedge clk); mem_ready = 1'b1;   // FETCH
      @(negedge clk); mem_ready = 1'b0; #1;
      e = '0; e.st = 3'd2;
`ifndef CONTROLE_ILLEGAL_TRAP_EN
      e.done = (k != 0);
`endif
      total++;
      if (obs !== e) begin bad++; $display("FAIL halt_decode op=%0d got=%h exp=%h", opcode, obs, e); end
      for (int c = 0; c < 3; c++) begin
        @(negedge clk); mem_ready = 1'($urandom_range(0, 1)); #1;
        e = '0;
        if (k == 0) begin e.st = 3'd6; e.hlt = 1'b1; end
`ifdef CONTROLE_ILLEGAL_TRAP_EN
        else begin e.st = 3'd6; e.hlt = 1'b1; e.ill = 1'b1; end
        total++;
        if (obs !== e) begin bad++; $display("FAIL halt_sticky op=%0d got=%h exp=%h", opcode, obs, e); end
`else
        else begin e.st = 3'd1; e.req = 1'b1; e.irw = mem_ready; e.pcw = mem_ready; end
        total++;
        if (obs !== e) begin bad++; $display("FAIL halt_sticky op=%0d got=%h exp=%h", opcode, obs, e); end
        if (k != 0) break;   // an illegal op retired as NOP: one FETCH check
`endif
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_mem();
    test_directed();
    test_timeout();
    test_halt_ops();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
